// File: rtl/bench_bist_ctrl.sv
// rtl/bench_bist_ctrl.sv - BIST sequencer: LFSR stimulus, MISR compaction and golden compare
//
// Drives one benchmark netlist through a pseudo-random test and compacts
// its responses into a 16-bit signature. This lets clean and modified
// netlists be told apart by a single compare.
//
// Ports:
//   clk          rising-edge clock for every register
//   reset        synchronous, active-high reset
//   start        one-cycle run request, honoured only in IDLE
//   abort        cancels a run in SETUP, RUN or COMPACT
//   num_vectors  vector count, latched with start (0 = request ignored)
//   golden       expected signature, latched with start
//   dut_in       stimulus to the benchmark (LFSR low bits during RUN)
//   dut_rst_n    active-low benchmark reset, released only in RUN/COMPACT
//   dut_out      benchmark outputs (registered inside the benchmark)
//   busy         high in SETUP, RUN and COMPACT
//   done         one-cycle completion pulse
//   pass         last completed signature matched golden
//   signature    last completed MISR value
module bench_bist_ctrl #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 6,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      num_vectors,
  input  logic [15:0]      golden,
  output logic [IN_W-1:0]  dut_in,
  output logic             dut_rst_n,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_COMPACT,
    S_DONE
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, shared by the LFSR and the MISR
  function automatic logic [15:0] poly_step(input logic [15:0] r);
    poly_step = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       misr_q, misr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       nv_q, nv_d;
  logic [15:0]       golden_q, golden_d;
  logic [15:0]       sig_q, sig_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rst_n_q, rst_n_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic [15:0]       out_ext;
  logic [15:0]       misr_absorb;

  // Zero-extend the benchmark response; written bitwise so OUT_W=16 needs
  // no zero-width replication.
  always_comb begin
    out_ext = '0;
    out_ext[OUT_W-1:0] = dut_out;
  end

  assign misr_absorb = poly_step(misr_q) ^ out_ext;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    cnt_d    = cnt_q;
    nv_d     = nv_q;
    golden_d = golden_q;
    sig_d    = sig_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start; a zero count is not a run
        if (start && !abort && (num_vectors != 16'd0)) begin
          nv_d     = num_vectors;
          golden_d = golden;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          lfsr_d  = SEED;
          misr_d  = '0;
          cnt_d   = nv_q;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          lfsr_d = poly_step(lfsr_q);
          misr_d = misr_absorb;
          cnt_d  = cnt_q - 16'd1;
          // Leaving at 1 (not 0) keeps RUN at exactly num_vectors cycles and
          // never lets the counter wrap, even for 16'hFFFF.
          if (cnt_q == 16'd1) begin
            state_d = S_COMPACT;
          end
        end
      end

      S_COMPACT: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // Last absorb catches the response to the final vector; the result
          // goes straight into the published signature on the same edge.
          misr_d  = misr_absorb;
          sig_d   = misr_absorb;
          pass_d  = (misr_absorb == golden_q);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they describe.
    busy_d   = (state_d == S_SETUP) || (state_d == S_RUN) || (state_d == S_COMPACT);
    done_d   = (state_d == S_DONE);
    rst_n_d  = (state_d == S_RUN) || (state_d == S_COMPACT);
    dut_in_d = (state_d == S_RUN) ? lfsr_d[IN_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      misr_q   <= '0;
      cnt_q    <= '0;
      nv_q     <= '0;
      golden_q <= '0;
      sig_q    <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rst_n_q  <= 1'b0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      nv_q     <= nv_d;
      golden_q <= golden_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rst_n_q  <= rst_n_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign dut_rst_n = rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// tb/tb_bench_bist_ctrl.sv - self-checking bench for bench_bist_ctrl
module tb_bench_bist_ctrl;

  localparam int          IN_W      = 3;
  localparam int          OUT_W     = 6;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [5:0]  BENCH_RST = 6'h15;
  localparam logic [2:0]  T1_IN [4] = '{3'd1, 3'd3, 3'd7, 3'd0};

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [15:0]       num_vectors;
  logic [15:0]       golden;
  logic [IN_W-1:0]   dut_in;
  logic              dut_rst_n;
  logic [OUT_W-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       signature;

  int n_checks = 0;
  int n_pass   = 0;

  logic       stuck_zero;
  logic [5:0] bench_q;

  always #5 clk = ~clk;

  bench_bist_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SEED(SEED)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_vectors (num_vectors),
    .golden      (golden),
    .dut_in      (dut_in),
    .dut_rst_n   (dut_rst_n),
    .dut_out     (dut_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature)
  );

  // Small sequential stand-in for the benchmark: registered, async active-low reset
  function automatic logic [5:0] bench_next(input logic [5:0] s, input logic [2:0] x);
    bench_next = {s[4:0], s[5] ^ x[0]} ^ {x[2] & s[1], x[1] | s[3], 1'b0, x[2] ^ s[0], 2'b00};
  endfunction

  always @(posedge clk or negedge dut_rst_n) begin
    if (!dut_rst_n) bench_q <= BENCH_RST;
    else            bench_q <= bench_next(bench_q, dut_in);
  end

  assign dut_out = stuck_zero ? 6'd0 : bench_q;

  // Polynomial taps 16,14,13,11 as a mask on bits 15,13,12,10
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    lfsr_next = {r[14:0], ^(r & 16'hB400)};
  endfunction

  // Expected signature: N vectors drive the benchmark, N+1 responses
  // (starting from its reset state) are folded into a zeroed MISR.
  function automatic logic [15:0] ref_sig(input logic [15:0] n, input logic bench_on);
    logic [15:0] v;
    logic [5:0]  s;
    logic [15:0] m;
    v = SEED;
    s = BENCH_RST;
    m = 16'h0000;
    for (int j = 0; j <= int'(n); j++) begin
      m = lfsr_next(m) ^ {10'b0, (bench_on ? s : 6'd0)};
      s = bench_next(s, v[2:0]);
      v = lfsr_next(v);
    end
    return m;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run; returns in the first IDLE cycle after done
  task automatic do_run(input logic [15:0] n, input logic [15:0] g, input logic bench_on,
                        output logic [15:0] exp_sig);
    logic [15:0] v;
    int cyc;
    int busy_cnt;
    exp_sig     = ref_sig(n, bench_on);
    stuck_zero  = !bench_on;
    num_vectors = n;
    golden      = g;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    cyc         = 1;
    busy_cnt    = 0;
    v           = SEED;
    while (!done && cyc < int'(n) + 10) begin
      if (busy) busy_cnt++;
      if (n <= 16'd200 && cyc >= 2 && cyc <= int'(n) + 1) begin
        check16("run dut_in", {13'b0, dut_in}, {13'b0, v[2:0]});
        v = lfsr_next(v);
      end
      tick();
      cyc++;
    end
    checki("done cycle", cyc, int'(n) + 3);
    checki("busy cycles", busy_cnt, int'(n) + 2);
    check1("done high", done, 1'b1);
    check1("busy in done", busy, 1'b0);
    check1("dut_rst_n in done", dut_rst_n, 1'b0);
    check16("signature", signature, exp_sig);
    check1("pass", pass, exp_sig == g);
    tick();
    check1("done one cycle", done, 1'b0);
    check16("signature hold", signature, exp_sig);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] g;
    logic [15:0] n;
    int cyc;
    int cnt;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    num_vectors = 16'd0; golden = 16'd0; stuck_zero = 1'b0;
    tick(); tick();
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset pass", pass, 1'b0);
    check16("reset signature", signature, 16'h0000);
    check1("reset dut_rst_n", dut_rst_n, 1'b0);
    check16("reset dut_in", {13'b0, dut_in}, 16'h0000);
    reset = 1'b0;
    tick();

    // LFSR sequence, N=3, cycle-by-cycle
    num_vectors = 16'd3; golden = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check1($sformatf("t1 busy c%0d", c), busy, (c >= 1 && c <= 5));
      check1($sformatf("t1 done c%0d", c), done, (c == 6));
      check1($sformatf("t1 dut_rst_n c%0d", c), dut_rst_n, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5)
        check16($sformatf("t1 dut_in c%0d", c), {13'b0, dut_in}, {13'b0, T1_IN[c-2]});
      if (c == 7)
        check16("t1 dut_in idle", {13'b0, dut_in}, 16'h0000);
      tick();
    end

    // Stuck-at-zero benchmark
    do_run(16'd8, 16'h0000, 1'b0, e1);
    check16("stuck sig zero", signature, 16'h0000);
    check1("stuck pass", pass, 1'b1);
    do_run(16'd8, 16'h0001, 1'b0, e1);
    check1("stuck golden1 pass", pass, 1'b0);

    // Randomised runs with benchmark attached
    for (int i = 0; i < 6; i++) begin
      n = 16'($urandom_range(1, 80));
      g = ($urandom_range(0, 1) == 1) ? ref_sig(n, 1'b1) : 16'($urandom);
      do_run(n, g, 1'b1, e1);
    end

    // Repeatability, N=100, back-to-back
    g = 16'($urandom);
    do_run(16'd100, g, 1'b1, e1);
    do_run(16'd100, e1, 1'b1, e2);
    check16("repeat signature", e2, e1);
    check1("repeat pass", pass, 1'b1);

    // Abort in RUN cycle 5 of N=20
    num_vectors = 16'd20; golden = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check1("abort pre busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check1("abort busy", busy, 1'b0);
    check1("abort done", done, 1'b0);
    check1("abort pass", pass, 1'b0);
    check1("abort dut_rst_n", dut_rst_n, 1'b0);
    check16("abort signature", signature, e2);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) cnt++;
      tick();
    end
    checki("abort no activity", cnt, 0);

    // start while busy ignored; start in DONE ignored
    e1 = ref_sig(16'd10, 1'b1);
    num_vectors = 16'd10; golden = e1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (cyc == 4) begin
        num_vectors = 16'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    checki("busy start done cycle", cyc, 13);
    check16("busy start signature", signature, e1);
    check1("busy start pass", pass, 1'b1);
    num_vectors = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check1("done start busy c1", busy, 1'b0);
    tick();
    check1("done start busy c2", busy, 1'b0);

    // start with N=0
    num_vectors = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (busy) cnt++;
      tick();
    end
    checki("zero count busy", cnt, 0);

    // start and abort together
    num_vectors = 16'd5; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (busy || dut_rst_n) cnt++;
      tick();
    end
    checki("start+abort no run", cnt, 0);
    check16("start+abort signature", signature, e1);

    // reset during COMPACT
    num_vectors = 16'd5; golden = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    check1("compact busy", busy, 1'b1);
    check1("compact dut_rst_n", dut_rst_n, 1'b1);
    check16("compact dut_in", {13'b0, dut_in}, 16'h0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("midrst busy", busy, 1'b0);
    check1("midrst done", done, 1'b0);
    check1("midrst pass", pass, 1'b0);
    check16("midrst signature", signature, 16'h0000);
    check1("midrst dut_rst_n", dut_rst_n, 1'b0);
    check16("midrst dut_in", {13'b0, dut_in}, 16'h0000);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || busy) cnt++;
      tick();
    end
    checki("midrst no done", cnt, 0);

    // Maximum count
    e1 = ref_sig(16'hFFFF, 1'b1);
    do_run(16'hFFFF, e1, 1'b1, e2);
    check1("max pass", pass, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
